// File: rtl/pq_pkg.sv
// Shared widths and enumerations for the priority-queue request scheduler.
package pq_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ID_WIDTH   = 4;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_PUSH = 2'd1,
        SCHED_POP  = 2'd2,
        SCHED_DROP = 2'd3
    } sched_state_e;

    typedef enum logic [1:0] {
        CLS_POP  = 2'd0,
        CLS_PUSH = 2'd1,
        CLS_DROP = 2'd2
    } sched_class_e;

    // Class rotation order POP -> PUSH -> DROP -> POP.
    function automatic sched_class_e next_class(input sched_class_e c);
        case (c)
            CLS_POP:  return CLS_PUSH;
            CLS_PUSH: return CLS_DROP;
            default:  return CLS_POP;
        endcase
    endfunction

endpackage

// File: rtl/pq_rr_arb.sv
// Round-robin arbiter: one-hot grant from req_i, pointer moves past the served requester on adv_i.
module pq_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    input  logic [NUM_REQ-1:0] adv_gnt_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PW'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (adv_gnt_i[j]) begin
                ptr_d = (j == NUM_REQ - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/pq_scheduler.sv
// Arbitrates push/drop requesters and downstream pops onto a single priority-queue command port.
module pq_scheduler
    import pq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DW      = DATA_WIDTH,
    parameter int IDW     = ID_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_REQ-1:0]     req_push_i,
    input  logic [NUM_REQ*DW-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]     req_drop_i,
    input  logic [NUM_REQ*IDW-1:0] req_drop_id_i,
    output logic [NUM_REQ-1:0]     req_ack_o,
    output logic [IDW-1:0]         req_id_o,
    output logic                   deq_valid_o,
    input  logic                   deq_ready_i,
    output logic [DW-1:0]          deq_data_o,
    output logic                   pq_push_o,
    output logic                   pq_pop_o,
    output logic                   pq_drop_o,
    output logic [DW-1:0]          pq_data_o,
    output logic [IDW-1:0]         pq_drop_id_o,
    input  logic                   pq_push_rdy_i,
    input  logic                   pq_pop_rdy_i,
    input  logic                   pq_drop_rdy_i,
    input  logic                   pq_empty_i,
    input  logic [IDW-1:0]         pq_push_id_i,
    input  logic [DW-1:0]          pq_data_i
);

    sched_state_e       state_q, state_d;
    sched_class_e       cls_ptr_q, pick_cls, c;
    logic               pick_valid, elig;
    logic [NUM_REQ-1:0] sel_q, ack_q;
    logic               ack_push_q;
    logic [IDW-1:0]     id_q, drop_id_q, drop_id_sel;
    logic [DW-1:0]      pq_data_q, deq_data_q, push_data_sel;
    logic               deq_valid_q;
    logic [NUM_REQ-1:0] push_req, drop_req, gnt_push, gnt_drop;
    logic               pop_elig, push_elig, drop_elig;
    logic               push_done, drop_done, pop_done;

    // A requester seen acked this cycle is still holding its line; hide it for that class only.
    assign push_req  = req_push_i & ~(ack_push_q ? ack_q : '0);
    assign drop_req  = req_drop_i & ~(ack_push_q ? '0 : ack_q);
    assign pop_elig  = !pq_empty_i && !deq_valid_q;
    assign push_elig = |push_req;
    assign drop_elig = |drop_req;

    assign push_done = (state_q == SCHED_PUSH) && pq_push_rdy_i;
    assign drop_done = (state_q == SCHED_DROP) && pq_drop_rdy_i;
    assign pop_done  = (state_q == SCHED_POP)  && pq_pop_rdy_i;

    pq_rr_arb #(.NUM_REQ(NUM_REQ)) u_push_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (push_req),
        .adv_i     (push_done),
        .adv_gnt_i (sel_q),
        .gnt_o     (gnt_push)
    );

    pq_rr_arb #(.NUM_REQ(NUM_REQ)) u_drop_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (drop_req),
        .adv_i     (drop_done),
        .adv_gnt_i (sel_q),
        .gnt_o     (gnt_drop)
    );

    always_comb begin
        push_data_sel = '0;
        drop_id_sel   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_push[k]) push_data_sel = req_data_i[k*DW +: DW];
            if (gnt_drop[k]) drop_id_sel   = req_drop_id_i[k*IDW +: IDW];
        end
    end

    always_comb begin
        pick_valid = 1'b0;
        pick_cls   = CLS_POP;
        elig       = 1'b0;
        c          = cls_ptr_q;
        for (int i = 0; i < 3; i++) begin
            case (c)
                CLS_POP:  elig = pop_elig;
                CLS_PUSH: elig = push_elig;
                CLS_DROP: elig = drop_elig;
                default:  elig = 1'b0;
            endcase
            if (!pick_valid && elig) begin
                pick_valid = 1'b1;
                pick_cls   = c;
            end
            c = next_class(c);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCHED_IDLE: begin
                if (pick_valid) begin
                    case (pick_cls)
                        CLS_PUSH: state_d = SCHED_PUSH;
                        CLS_DROP: state_d = SCHED_DROP;
                        default:  state_d = SCHED_POP;
                    endcase
                end
            end
            SCHED_PUSH: if (pq_push_rdy_i) state_d = SCHED_IDLE;
            SCHED_POP:  if (pq_pop_rdy_i)  state_d = SCHED_IDLE;
            SCHED_DROP: if (pq_drop_rdy_i) state_d = SCHED_IDLE;
            default:    state_d = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SCHED_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cls_ptr_q   <= CLS_POP;
            sel_q       <= '0;
            ack_q       <= '0;
            ack_push_q  <= 1'b0;
            id_q        <= '0;
            pq_data_q   <= '0;
            drop_id_q   <= '0;
            deq_valid_q <= 1'b0;
            deq_data_q  <= '0;
        end else begin
            ack_q <= '0;
            if (deq_valid_q && deq_ready_i) deq_valid_q <= 1'b0;
            if (state_q == SCHED_IDLE && pick_valid) begin
                cls_ptr_q <= next_class(pick_cls);
                case (pick_cls)
                    CLS_PUSH: begin
                        sel_q     <= gnt_push;
                        pq_data_q <= push_data_sel;
                    end
                    CLS_DROP: begin
                        sel_q     <= gnt_drop;
                        drop_id_q <= drop_id_sel;
                    end
                    default: sel_q <= '0;
                endcase
            end
            if (push_done) begin
                ack_q      <= sel_q;
                ack_push_q <= 1'b1;
                id_q       <= pq_push_id_i;
            end
            if (drop_done) begin
                ack_q      <= sel_q;
                ack_push_q <= 1'b0;
                id_q       <= '0;
            end
            if (pop_done) begin
                deq_data_q  <= pq_data_i;
                deq_valid_q <= 1'b1;
            end
        end
    end

    assign pq_push_o    = (state_q == SCHED_PUSH);
    assign pq_pop_o     = (state_q == SCHED_POP);
    assign pq_drop_o    = (state_q == SCHED_DROP);
    assign pq_data_o    = pq_data_q;
    assign pq_drop_id_o = drop_id_q;
    assign req_ack_o    = ack_q;
    assign req_id_o     = id_q;
    assign deq_valid_o  = deq_valid_q;
    assign deq_data_o   = deq_data_q;

endmodule
